// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the multi-cycle divider sequencer.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider request/result bundle.
interface div_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic               busy_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  busy_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and trial-subtract.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] next_rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Shifted value is WIDTH+1 bits wide; when the subtraction succeeds the
  // difference is below the divisor, so the low WIDTH bits are exact.
  assign shifted    = {rem_i, dvd_msb_i};
  assign q_bit_o    = (shifted >= {1'b0, divisor_i});
  assign diff       = shifted[WIDTH-1:0] - divisor_i;
  assign next_rem_o = q_bit_o ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_ctrl.sv
// Radix-2 restoring DIV/DIVU sequencer; one quotient bit per cycle plus a sign-fix cycle.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               signed_q, signed_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic               accept;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i      (rem_q),
    .dvd_msb_i  (dvd_q[WIDTH-1]),
    .divisor_i  (divisor_q),
    .next_rem_o (step_rem),
    .q_bit_o    (step_q)
  );

  assign accept = (bus.start_i == DivStart) && !bus.annul_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    ready_d   = ready_q;
    result_d  = result_q;

    unique case (state_q)
      DivFree: begin
        if (accept) begin
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            signed_d  = bus.signed_i;
            sign1_d   = bus.opdata1_i[WIDTH-1];
            sign2_d   = bus.opdata2_i[WIDTH-1];
            dvd_d     = cond_neg(bus.opdata1_i, bus.signed_i && bus.opdata1_i[WIDTH-1]);
            divisor_d = cond_neg(bus.opdata2_i, bus.signed_i && bus.opdata2_i[WIDTH-1]);
            rem_d     = '0;
          end
        end
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = DivResultReady;
        state_d  = DivEnd;
      end
      DivOn: begin
        if (bus.annul_i) begin
          state_d = DivFree;
        end else if (cnt_q != CNT_W'(WIDTH)) begin
          // Quotient bits shift into the vacated low end of the dividend register.
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = {cond_neg(rem_q, signed_q && sign1_q),
                      cond_neg(dvd_q, signed_q && (sign1_q ^ sign2_q))};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
      end
      DivEnd: begin
        if ((bus.start_i == DivStop) || bus.annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      ready_q   <= DivResultNotReady;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy_o   = (state_q == DivOn) || (state_q == DivByZero) ||
                        ((state_q == DivFree) && accept);
  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomized checks of div_ctrl against an arithmetic reference.
module tb_div_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  div_ctrl_if #(.WIDTH(32)) bus ();

  div_ctrl #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {remainder, quotient}; SV integer division truncates toward zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input string tag);
    logic [63:0] exp;
    int          lat_exp;
    int          n;
    logic        busy_ok;
    exp     = ref_div(a, b, sgn);
    lat_exp = (b == 32'h0) ? 2 : 34;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.signed_i  = sgn;
    bus.start_i   = 1'b1;
    #1;
    chk({tag, "_busy_req"}, 64'(bus.busy_o), 64'h1);
    step();
    n = 1;
    // Operands changed mid-flight must not disturb the divide.
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    bus.signed_i  = ~sgn;
    busy_ok = 1'b1;
    while (!bus.ready_o && n < 60) begin
      busy_ok &= bus.busy_o;
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat_exp));
    chk({tag, "_busy_run"}, 64'(busy_ok), 64'h1);
    chk({tag, "_result"}, bus.result_o, exp);
    chk({tag, "_busy_end"}, 64'(bus.busy_o), 64'h0);
    step();
    chk({tag, "_result_hold"}, bus.result_o, exp);
    bus.start_i = 1'b0;
    step();
    chk({tag, "_ready_clr"}, 64'(bus.ready_o), 64'h0);
    chk({tag, "_result_clr"}, bus.result_o, 64'h0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    tests = 0;
    fails = 0;
    rst           = 1'b0;
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_ready", 64'(bus.ready_o), 64'h0);
    chk("rst_result", bus.result_o, 64'h0);
    chk("rst_busy", 64'(bus.busy_o), 64'h0);

    run_div(32'd7, 32'd2, 1'b0, "divu_7_2");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
    run_div(32'd5, 32'd0, 1'b1, "div_by0");
    run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "divu_bigdiv");

    // Flush in the middle of a divide.
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.signed_i  = 1'b0;
    bus.start_i   = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.annul_i = 1'b1;
    step();
    chk("annul_busy", 64'(bus.busy_o), 64'h0);
    chk("annul_ready", 64'(bus.ready_o), 64'h0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    step();
    chk("annul_idle_ready", 64'(bus.ready_o), 64'h0);
    chk("annul_idle_busy", 64'(bus.busy_o), 64'h0);
    run_div(32'd100, 32'd7, 1'b0, "after_annul");

    // Reset in the middle of a divide.
    bus.opdata1_i = 32'd12345;
    bus.opdata2_i = 32'd17;
    bus.start_i   = 1'b1;
    for (int i = 0; i < 20; i++) step();
    rst         = 1'b0;
    bus.start_i = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_ready", 64'(bus.ready_o), 64'h0);
    chk("midrst_result", bus.result_o, 64'h0);
    chk("midrst_busy", 64'(bus.busy_o), 64'h0);
    step();
    chk("midrst_stay_ready", 64'(bus.ready_o), 64'h0);
    run_div(32'hFFFF_FF00, 32'd9, 1'b1, "after_rst");

    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(1, 15));
        1: b = (b & 32'h8000_000F) | 32'hFFFF_FFF0;
        2: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_div(a, b, s, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
